multicycle_cu: RTL
==================

Name: multicycle_cu

Overview:
- Parametrised multi-cycle successor to the single-cycle CUFinal control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, driving the same datapath strobes (pcsrc, aluop, immsel, wb, alusrc, regrw, memrw, ramen) to the TopLab8 datapath.
- Adds condition-code evaluation against NZCV status, a RAM request/acknowledge handshake with timeout, and sticky illegal/timeout error reporting.
- Sits between the instruction source and the datapath, inside the CPU top level.

Parameters:
- ALUOP_W, 4: width of aluop; the instruction field instr[24:21] is zero-extended or truncated to this width.
- ALU_ADD, 4'b0100: aluop code issued for load/store address generation.
- MEM_TIMEOUT, 15: consecutive no-ack MEM cycles that trigger an error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word; sampled only in FETCH.
- instr_valid  in  1  instr is valid this cycle.
- status  in  4  flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- ram_ack  in  1  RAM access complete.
- ir_we  out  1  one-cycle pulse when an instruction is accepted.
- pc_we  out  1  PC update strobe.
- pcsrc  out  1  PC source: 0 = PC+4, 1 = branch target.
- aluop  out  ALUOP_W  ALU operation.
- immsel  out  2  immediate select: 00 = DP, 01 = memory offset, 10 = branch.
- alusrc  out  1  ALU operand B: 1 = immediate.
- regrw  out  1  register-file write enable.
- wb  out  1  write-back source: 1 = RAM data, 0 = ALU result.
- ramen  out  1  RAM request.
- memrw  out  1  RAM direction: 1 = write, 0 = read.
- busy  out  1  high in every state except FETCH and the error states.
- illegal  out  1  sticky illegal-instruction flag.
- timeout  out  1  sticky RAM-timeout flag.
- state_o  out  3  current state, for debug.

Behaviour:
- Instruction fields:
  - cond = instr[31:28]
  - class = instr[27:26]: 00 = DP, 01 = LS, 10 = BR, 11 = illegal
  - I = instr[25]
  - op = instr[24:21]
  - L = instr[20] (1 = load)
- The whole instr is latched into an internal IR on acceptance. All outputs are decoded combinationally from the state register and the IR, never from the live instr input. Any output not listed for a state is 0.
- Reset (asserted low):
  - Asynchronously forces FETCH, clears IR, the wait counter, illegal and timeout.
  - All outputs read 0. An in-flight RAM access is abandoned (ramen drops at once).
- FETCH:
  - Waits for instr_valid.
  - On valid: ir_we=1, latch IR, go to DECODE.
- DECODE:
  - Evaluates cond against the status value present this cycle. Codes follow ARM: 0000 EQ … 1101 LE, 1110 AL.
  - cond==1111 or class==11: go to ILLEGAL and set illegal.
  - Condition false: pc_we=1, pcsrc=0, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - DP: aluop=op, alusrc=I, immsel=00, go to WB.
  - LS: aluop=ALU_ADD, alusrc=1, immsel=01, go to MEM.
  - BR: immsel=10, pc_we=1, pcsrc=1, go to FETCH.
- MEM:
  - ramen=1, memrw=~L, aluop/alusrc/immsel held as in EXEC. Hold until ram_ack.
  - On ack: a load goes to WB; a store asserts pc_we=1, pcsrc=0 and goes to FETCH.
  - The wait counter increments on each no-ack cycle. When it reaches MEM_TIMEOUT (if nonzero), go to TIMEOUT and set timeout.
  - ram_ack in the same cycle as the limit: ack wins.
  - The counter clears on entry to MEM.
- WB: regrw=1, wb=(class==LS), pc_we=1, pcsrc=0, go to FETCH.
- ILLEGAL and TIMEOUT are terminal until reset. All strobes are 0 and busy=0.
- Ignored inputs: instr_valid outside FETCH; ram_ack outside MEM.
- Latency, from the instr_valid cycle to the next FETCH:
  - DP: 4 cycles
  - BR: 3 cycles
  - failed condition: 2 cycles
  - store: 4 + wait cycles
  - load: 5 + wait cycles
- state_o encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ILLEGAL=5, TIMEOUT=6.

Decomposition:
- Package multicycle_cu_pkg holds:
  - the state enum
  - class codes
  - condition codes
  - immsel encodings
  - status bit indices
- One sub-module, cond_eval: purely combinational, inputs cond[3:0] and status[3:0], output pass; 1111 yields pass=0.

Test Plan:
- DP, instr=32'hE2800000 (AL, DP, I=1, op=0100), valid held high:
  - ir_we in cycle 0; aluop=0100 and alusrc=1 in EXEC; regrw=1, wb=0, pc_we=1 in WB.
  - Back in FETCH at cycle 4.
- Conditional skip, cond=0000 (EQ) with status=4'b0000:
  - pc_we=1, pcsrc=0 in DECODE; regrw never asserted; back in FETCH after 2 cycles.
- Load (class 01, L=1) with ram_ack after 3 wait cycles:
  - ramen=1, memrw=0 for 4 cycles, then WB with regrw=1, wb=1.
- Store (L=0), ram_ack never asserted, MEM_TIMEOUT=15:
  - After 15 MEM cycles, TIMEOUT entered: timeout=1, ramen=0, busy=0.
  - reset low clears it to FETCH.
- Illegal cond=1111: illegal=1 and state_o=5 after DECODE; later instr_valid pulses produce no ir_we.
- Reset asserted mid-MEM: outputs 0 asynchronously, before the next clk edge; after release, state_o=0 and the next instruction executes normally.

Source files
------------

// File: rtl/multicycle_cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Holds the FSM state enum, the instruction word layout, class, condition
// and immediate-select codes, and the NZCV status bit positions.
package multicycle_cu_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned COND_W   = 4;
    localparam int unsigned STATUS_W = 4;

    // Debug-visible state encoding; values are exported on state_o.
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_ILLEGAL = 3'd5,
        ST_TIMEOUT = 3'd6
    } state_e;

    // Instruction word layout, MSB first.
    typedef struct packed {
        logic [3:0]  cond;   // [31:28]
        logic [1:0]  cls;    // [27:26]
        logic        imm;    // [25]
        logic [3:0]  op;     // [24:21]
        logic        load;   // [20]
        logic [19:0] rest;   // [19:0], consumed by the datapath only
    } instr_t;

    // Instruction classes.
    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_LS  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ILL = 2'b11;

    // ARM condition codes.
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Immediate-select encodings.
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // Status flag bit positions.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/multicycle_cu_cond_eval.sv
// Condition-code evaluator: decides whether an instruction's cond field
// passes against the current NZCV flags. Purely combinational.
//   cond   in  4  ARM condition field
//   status in  4  flags [3]=N [2]=Z [1]=C [0]=V
//   pass   out 1  1 when the instruction should execute; 1111 never passes
module cond_eval
    import multicycle_cu_pkg::*;
(
    input  logic [COND_W-1:0]   cond,
    input  logic [STATUS_W-1:0] status,
    output logic                pass
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = status[FLAG_N];
    assign z_flag = status[FLAG_Z];
    assign c_flag = status[FLAG_C];
    assign v_flag = status[FLAG_V];

    // ARM condition table.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_flag;
            COND_NE: pass = !z_flag;
            COND_CS: pass = c_flag;
            COND_CC: pass = !c_flag;
            COND_MI: pass = n_flag;
            COND_PL: pass = !n_flag;
            COND_VS: pass = v_flag;
            COND_VC: pass = !v_flag;
            COND_HI: pass = c_flag && !z_flag;
            COND_LS: pass = !c_flag || z_flag;
            COND_GE: pass = (n_flag == v_flag);
            COND_LT: pass = (n_flag != v_flag);
            COND_GT: pass = !z_flag && (n_flag == v_flag);
            COND_LE: pass = z_flag || (n_flag != v_flag);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
//   clk, reset (async, active low)
//   instr/instr_valid  instruction source, sampled in FETCH only
//   status             NZCV flags, used in DECODE
//   ram_ack            RAM completion, used in MEM only
//   ir_we, pc_we, pcsrc, aluop, immsel, alusrc, regrw, wb, ramen, memrw
//                      datapath strobes, decoded from state and IR
//   busy, illegal, timeout, state_o  status/debug
module multicycle_cu
    import multicycle_cu_pkg::*;
#(
    parameter int unsigned        ALUOP_W     = 4,
    parameter logic [ALUOP_W-1:0] ALU_ADD     = ALUOP_W'(4'b0100),
    parameter int unsigned        MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  instr_valid,
    input  logic [STATUS_W-1:0]   status,
    input  logic                  ram_ack,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  pcsrc,
    output logic [ALUOP_W-1:0]    aluop,
    output logic [1:0]            immsel,
    output logic                  alusrc,
    output logic                  regrw,
    output logic                  wb,
    output logic                  ramen,
    output logic                  memrw,
    output logic                  busy,
    output logic                  illegal,
    output logic                  timeout,
    output logic [STATE_W-1:0]    state_o
);

    localparam int unsigned CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic        TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_e           state_q;
    state_e           state_d;
    instr_t           ir_q;
    instr_t           ir_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             illegal_q;
    logic             illegal_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             accept_c;
    logic             cond_pass;
    logic             timeout_hit;
    logic             unused_ir;

    cond_eval u_cond_eval (
        .cond   (ir_q.cond),
        .status (status),
        .pass   (cond_pass)
    );

    // Saturating wait counter; saturation only matters when the timeout is disabled.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_W'(MEM_TIMEOUT));

    // State, IR, counter and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and strobe decode from state register and IR.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        accept_c  = 1'b0;
        pc_we     = 1'b0;
        pcsrc     = 1'b0;
        aluop     = '0;
        immsel    = IMM_DP;
        alusrc    = 1'b0;
        regrw     = 1'b0;
        wb        = 1'b0;
        ramen     = 1'b0;
        memrw     = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    accept_c = 1'b1;
                    ir_d     = instr_t'(instr);
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                busy = 1'b1;
                if (ir_q.cond == COND_NV || ir_q.cls == CLS_ILL) begin
                    state_d   = ST_ILLEGAL;
                    illegal_d = 1'b1;
                end else if (!cond_pass) begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                busy = 1'b1;
                case (ir_q.cls)
                    CLS_DP: begin
                        aluop   = ALUOP_W'(ir_q.op);
                        alusrc  = ir_q.imm;
                        state_d = ST_WB;
                    end
                    CLS_LS: begin
                        aluop   = ALU_ADD;
                        alusrc  = 1'b1;
                        immsel  = IMM_MEM;
                        state_d = ST_MEM;
                    end
                    CLS_BR: begin
                        immsel  = IMM_BR;
                        pc_we   = 1'b1;
                        pcsrc   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        // Unreachable: DECODE already trapped class 11.
                        state_d   = ST_ILLEGAL;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            ST_MEM: begin
                busy   = 1'b1;
                ramen  = 1'b1;
                memrw  = !ir_q.load;
                aluop  = ALU_ADD;
                alusrc = 1'b1;
                immsel = IMM_MEM;
                // Ack takes priority over the timeout limit in the same cycle.
                if (ram_ack) begin
                    if (ir_q.load) begin
                        state_d = ST_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_WB: begin
                busy    = 1'b1;
                regrw   = 1'b1;
                wb      = (ir_q.cls == CLS_LS);
                pc_we   = 1'b1;
                state_d = ST_FETCH;
            end

            ST_ILLEGAL, ST_TIMEOUT: begin
                state_d = state_q;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // ir_we follows the live instr_valid, so it must be held low during reset.
    assign ir_we     = accept_c && reset;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign state_o   = state_q;
    assign unused_ir = ^ir_q.rest;

endmodule
